// File: rtl/glyph_pkg.sv
// Shared constants, FSM state type and address helper for the glyph pixel fetch path.
package glyph_pkg;

  localparam logic [14:0] GLYPH_OFFSET_DEFAULT = 15'h400;
  localparam int unsigned GLYPH_ROWS = 8;
  localparam int unsigned GLYPH_COLS = 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StShift
  } glyph_state_e;

  // Two glyph rows share one 16-bit word; the sum wraps modulo 2^15.
  function automatic logic [14:0] glyph_row_addr(input logic [7:0]  glyph,
                                                 input logic [2:0]  row,
                                                 input logic [14:0] offset);
    return {5'd0, glyph, row[2:1]} + offset;
  endfunction

endpackage

// File: rtl/glyph_row_shifter.sv
// Loadable 8-bit MSB-first pixel shifter with a PIX_DIV prescaler, pixel counter and last-cycle flag.
module glyph_row_shifter
  import glyph_pkg::*;
#(
  parameter int unsigned PIX_DIV = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       pixel_o,
  output logic       valid_o,
  output logic       active_o,
  output logic       last_o
);

  localparam logic [3:0] DivLast = 4'(PIX_DIV - 1);
  localparam logic [2:0] PixLast = 3'(GLYPH_COLS - 1);

  logic [6:0] sr_q;
  logic [3:0] div_q;
  logic [2:0] cnt_q;
  logic       active_q;
  logic       pix_q;
  logic       valid_q;
  logic       div_end;

  assign div_end  = (div_q == DivLast);
  // High in the final cycle of the final pixel; a load here continues without a gap.
  assign last_o   = active_q && div_end && (cnt_q == PixLast);
  assign pixel_o  = pix_q;
  assign valid_o  = valid_q;
  assign active_o = active_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sr_q     <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      pix_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else if (load_i) begin
      sr_q     <= data_i[6:0];
      pix_q    <= data_i[7];
      valid_q  <= 1'b1;
      active_q <= 1'b1;
      div_q    <= '0;
      cnt_q    <= '0;
    end else if (active_q) begin
      if (div_end) begin
        div_q <= '0;
        if (cnt_q == PixLast) begin
          active_q <= 1'b0;
          pix_q    <= 1'b0;
          valid_q  <= 1'b0;
        end else begin
          pix_q   <= sr_q[6];
          sr_q    <= {sr_q[5:0], 1'b0};
          cnt_q   <= cnt_q + 3'd1;
          valid_q <= 1'b1;
        end
      end else begin
        div_q   <= div_q + 4'd1;
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/glyph_pixel_fetch.sv
// Glyph-row fetch FSM: forms the word address, runs the req/gnt/rvalid read and feeds the shifter.
// Define GLYPH_PREFETCH_EN to add a one-deep holding slot that overlaps the next fetch with shifting.
module glyph_pixel_fetch
  import glyph_pkg::*;
#(
  parameter logic [14:0] GLYPH_OFFSET = GLYPH_OFFSET_DEFAULT,
  parameter int unsigned PIX_DIV      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  glyph,
  input  logic [2:0]  row,
  output logic        mem_req,
  output logic [14:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        pixel_out,
  output logic        pixel_valid,
  output logic        busy,
  output logic        underrun
);

  glyph_state_e state_q;
  logic         req_q;
  logic [14:0]  addr_q;
  logic         row0_q;
  logic         underrun_q;
  logic [7:0]   byte_sel;
  logic         rv_direct;
  logic         shift_load;
  logic [7:0]   shift_data;
  logic         shift_active;
  logic         shift_last;
`ifdef GLYPH_PREFETCH_EN
  logic [7:0]   hold_q;
  logic         hold_valid_q;
  logic         hold_pop;
`endif

  always_comb begin
    byte_sel  = row0_q ? mem_rdata[7:0] : mem_rdata[15:8];
    // Returned data goes straight to the shifter when it is free or about to be.
    rv_direct = (state_q == StWait) && mem_rvalid && (!shift_active || shift_last);
`ifdef GLYPH_PREFETCH_EN
    hold_pop   = (state_q == StShift) && hold_valid_q && shift_last;
    shift_load = rv_direct || hold_pop;
    shift_data = hold_pop ? hold_q : byte_sel;
`else
    shift_load = rv_direct;
    shift_data = byte_sel;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      addr_q     <= '0;
      row0_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef GLYPH_PREFETCH_EN
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
`endif
    end else begin
      underrun_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q  <= glyph_row_addr(glyph, row, GLYPH_OFFSET);
            row0_q  <= row[0];
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          underrun_q <= start;
          if (mem_gnt) begin
            req_q   <= 1'b0;
            state_q <= StWait;
          end
        end
        StWait: begin
          underrun_q <= start;
          if (mem_rvalid) begin
`ifdef GLYPH_PREFETCH_EN
            if (!rv_direct) begin
              hold_q       <= byte_sel;
              hold_valid_q <= 1'b1;
            end
`endif
            state_q <= StShift;
          end
        end
        StShift: begin
`ifdef GLYPH_PREFETCH_EN
          if (start && !hold_valid_q) begin
            addr_q  <= glyph_row_addr(glyph, row, GLYPH_OFFSET);
            row0_q  <= row[0];
            req_q   <= 1'b1;
            state_q <= StReq;
          end else begin
            underrun_q <= start;
            if (shift_last && !hold_valid_q) state_q <= StIdle;
          end
          if (hold_pop) hold_valid_q <= 1'b0;
`else
          underrun_q <= start;
          if (shift_last) state_q <= StIdle;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  glyph_row_shifter #(
    .PIX_DIV (PIX_DIV)
  ) u_shifter (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (shift_load),
    .data_i   (shift_data),
    .pixel_o  (pixel_out),
    .valid_o  (pixel_valid),
    .active_o (shift_active),
    .last_o   (shift_last)
  );

  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign busy     = (state_q != StIdle);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_glyph_pixel_fetch.sv
// Bench for glyph_pixel_fetch: two instances (default and wrapped-offset/PIX_DIV=4) share stimulus.
module tb_glyph_pixel_fetch;

  localparam logic [14:0] OFF0 = 15'h400;
  localparam int          DIV0 = 1;
  localparam logic [14:0] OFF1 = 15'h7E00;
  localparam int          DIV1 = 4;

  logic        clk = 1'b0;
  logic        reset, start, mem_gnt, mem_rvalid;
  logic [7:0]  glyph;
  logic [2:0]  row;
  logic [15:0] mem_rdata;
  logic [1:0]  mem_req_w, pixel_out_w, pixel_valid_w, busy_w, underrun_w;
  logic [14:0] mem_addr0, mem_addr1, last_addr0, last_addr1;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int ones0  = 0;
  int ones1  = 0;
  int m0, m1, o0, o1;
  logic vb0[$];
  logic vb1[$];
  int   vt0[$];
  int   vt1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  glyph_pixel_fetch #(.GLYPH_OFFSET(OFF0), .PIX_DIV(DIV0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .glyph(glyph), .row(row),
    .mem_req(mem_req_w[0]), .mem_addr(mem_addr0), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .pixel_out(pixel_out_w[0]), .pixel_valid(pixel_valid_w[0]),
    .busy(busy_w[0]), .underrun(underrun_w[0])
  );

  glyph_pixel_fetch #(.GLYPH_OFFSET(OFF1), .PIX_DIV(DIV1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .glyph(glyph), .row(row),
    .mem_req(mem_req_w[1]), .mem_addr(mem_addr1), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .pixel_out(pixel_out_w[1]), .pixel_valid(pixel_valid_w[1]),
    .busy(busy_w[1]), .underrun(underrun_w[1])
  );

  // Pixel log: value and cycle of every pixel_valid, plus cycles spent with pixel_out high.
  always @(negedge clk) begin
    if (pixel_valid_w[0] === 1'b1) begin
      vb0.push_back(pixel_out_w[0]);
      vt0.push_back(cyc);
    end
    if (pixel_valid_w[1] === 1'b1) begin
      vb1.push_back(pixel_out_w[1]);
      vt1.push_back(cyc);
    end
    if (pixel_out_w[0] === 1'b1) ones0 <= ones0 + 1;
    if (pixel_out_w[1] === 1'b1) ones1 <= ones1 + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int exp_addr(input int g, input int r, input int off);
    return (g * 4 + r / 2 + off) % 32768;
  endfunction

  function automatic logic [7:0] pick(input logic [2:0] r, input logic [15:0] d);
    return (r % 2 == 1) ? d[7:0] : d[15:8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    m0 = vb0.size();
    m1 = vb1.size();
    o0 = ones0;
    o1 = ones1;
  endtask

  task automatic fetch(input logic [7:0] g, input logic [2:0] r, input int gd, input int rd,
                       input logic [15:0] d, output int rv_cyc);
    int n;
    start = 1'b1;
    glyph = g;
    row   = r;
    step();
    start = 1'b0;
    glyph = 8'($urandom);
    row   = 3'($urandom);
    n = 0;
    while (mem_req_w[0] === 1'b1 && n < 40) begin
      if (n == 0) begin
        last_addr0 = mem_addr0;
        last_addr1 = mem_addr1;
      end
      chk("req_pair", 32'(mem_req_w[1]), 1);
      chk("addr0", 32'(mem_addr0), exp_addr(g, r, OFF0));
      chk("addr1", 32'(mem_addr1), exp_addr(g, r, OFF1));
      mem_gnt = (n == gd);
      n++;
      step();
    end
    mem_gnt = 1'b0;
    chk("req_cycles", n, gd + 1);
    repeat (rd - 1) step();
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    rv_cyc     = cyc;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_w !== 2'b00 && n < 300) begin
      step();
      n++;
    end
    chk(tag, 32'(busy_w), 0);
  endtask

  task automatic check_pix(input int inst, input int nbytes, input logic [15:0] bytes,
                           input int first, input string tag);
    int   cnt, mk, div, ones_d, pc, t;
    logic b;
    div = (inst == 0) ? DIV0 : DIV1;
    mk  = (inst == 0) ? m0 : m1;
    cnt = ((inst == 0) ? vb0.size() : vb1.size()) - mk;
    chk($sformatf("%s_npix%0d", tag, inst), cnt, 8 * nbytes);
    for (int k = 0; k < cnt && k < 8 * nbytes; k++) begin
      if (inst == 0) begin
        b = vb0[mk + k];
        t = vt0[mk + k];
      end else begin
        b = vb1[mk + k];
        t = vt1[mk + k];
      end
      chk($sformatf("%s_pix%0d_%0d", tag, inst, k), 32'(b), 32'(bytes[8 * nbytes - 1 - k]));
      chk($sformatf("%s_time%0d_%0d", tag, inst, k), t, first + k * div);
    end
    pc     = (nbytes == 2) ? $countones(bytes) : $countones(bytes[7:0]);
    ones_d = (inst == 0) ? ones0 - o0 : ones1 - o1;
    chk($sformatf("%s_ones%0d", tag, inst), ones_d, pc * div);
  endtask

  initial begin
    int          rv, gd, rd;
    logic [7:0]  g;
    logic [2:0]  r;
    logic [15:0] d, d2;

    reset = 1'b1; start = 1'b0; glyph = '0; row = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) step();
    chk("rst_outs", {22'd0, mem_req_w, pixel_out_w, pixel_valid_w, busy_w, underrun_w}, 0);
    chk("rst_addr", {2'd0, mem_addr0, mem_addr1}, 0);
    reset = 1'b0;
    step();

    // Directed vector: 'A', row 3, immediate grant.
    snap();
    fetch(8'h41, 3'd3, 0, 1, 16'h3C66, rv);
    wait_idle("t1_idle");
    chk("t1_addr", 32'(last_addr0), 32'h505);
    check_pix(0, 1, {8'h00, 8'b0110_0110}, rv + 1, "t1");
    check_pix(1, 1, {8'h00, 8'b0110_0110}, rv + 1, "t1");

    // Address wrap, then row 6 picks the high byte.
    snap();
    fetch(8'hFF, 3'd7, 1, 1, 16'h0000, rv);
    wait_idle("t2a_idle");
    chk("t2_wrap_addr", 32'(last_addr1), 32'h01FF);
    chk("t2_addr0", 32'(last_addr0), 32'h07FF);
    snap();
    fetch(8'hFF, 3'd6, 0, 2, 16'hA500, rv);
    wait_idle("t2b_idle");
    check_pix(0, 1, {8'h00, 8'b1010_0101}, rv + 1, "t2");
    check_pix(1, 1, {8'h00, 8'b1010_0101}, rv + 1, "t2");

    // Slow arbiter, then a stray rvalid while idle.
    snap();
    fetch(8'h5C, 3'd4, 3, 4, 16'h81F0, rv);
    wait_idle("t3_idle");
    check_pix(0, 1, {8'h00, pick(3'd4, 16'h81F0)}, rv + 1, "t3");
    check_pix(1, 1, {8'h00, pick(3'd4, 16'h81F0)}, rv + 1, "t3");
    snap();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hFFFF;
    step();
    mem_rvalid = 1'b0;
    repeat (12) step();
    chk("t3_spur_pix", (vb0.size() - m0) + (vb1.size() - m1), 0);
    chk("t3_spur_ones", (ones0 - o0) + (ones1 - o1), 0);
    chk("t3_spur_busy", 32'(busy_w), 0);

    // start while shifting.
    snap();
    d = 16'h5AC3;
    fetch(8'h12, 3'd2, 1, 2, d, rv);
    start = 1'b1;
    glyph = 8'h34;
    row   = 3'd5;
    step();
    start = 1'b0;
`ifdef GLYPH_PREFETCH_EN
    chk("t4_no_underrun", 32'(underrun_w), 0);
    chk("t4_req", 32'(mem_req_w), 32'b11);
    chk("t4_addr0", 32'(mem_addr0), exp_addr(8'h34, 5, OFF0));
    chk("t4_addr1", 32'(mem_addr1), exp_addr(8'h34, 5, OFF1));
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    d2         = 16'hC35A;
    mem_rvalid = 1'b1;
    mem_rdata  = d2;
    step();
    mem_rvalid = 1'b0;
    wait_idle("t4_idle");
    check_pix(0, 2, {pick(3'd2, d), pick(3'd5, d2)}, rv + 1, "t4");
    check_pix(1, 2, {pick(3'd2, d), pick(3'd5, d2)}, rv + 1, "t4");
`else
    chk("t4_underrun", 32'(underrun_w), 32'b11);
    step();
    chk("t4_underrun_pulse", 32'(underrun_w), 0);
    chk("t4_no_req", 32'(mem_req_w), 0);
    wait_idle("t4_idle");
    check_pix(0, 1, {8'h00, pick(3'd2, d)}, rv + 1, "t4");
    check_pix(1, 1, {8'h00, pick(3'd2, d)}, rv + 1, "t4");
`endif

    // Reset while waiting for data; the late rvalid must be ignored.
    snap();
    start = 1'b1;
    glyph = 8'h77;
    row   = 3'd1;
    step();
    start = 1'b0;
    chk("t5_req", 32'(mem_req_w), 32'b11);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("t5_wait_busy", 32'(busy_w), 32'b11);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_rst_outs", {22'd0, mem_req_w, pixel_out_w, pixel_valid_w, busy_w, underrun_w}, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hFFFF;
    step();
    mem_rvalid = 1'b0;
    repeat (10) step();
    chk("t5_busy", 32'(busy_w), 0);
    chk("t5_npix", (vb0.size() - m0) + (vb1.size() - m1), 0);
    chk("t5_ones", (ones0 - o0) + (ones1 - o1), 0);

    // start coincident with reset.
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("rs_busy", 32'(busy_w), 0);
    step();
    chk("rs_req", 32'(mem_req_w), 0);

    // Full-foreground row, checks PIX_DIV hold on the divided instance.
    snap();
    fetch(8'h20, 3'd0, 0, 1, 16'hFF00, rv);
    wait_idle("t6_idle");
    check_pix(0, 1, 16'h00FF, rv + 1, "t6");
    check_pix(1, 1, 16'h00FF, rv + 1, "t6");

    for (int i = 0; i < 8; i++) begin
      g  = 8'($urandom);
      r  = 3'($urandom);
      d  = 16'($urandom);
      gd = $urandom_range(0, 3);
      rd = $urandom_range(1, 4);
      snap();
      fetch(g, r, gd, rd, d, rv);
      wait_idle("rnd_idle");
      check_pix(0, 1, {8'h00, pick(r, d)}, rv + 1, "rnd");
      check_pix(1, 1, {8'h00, pick(r, d)}, rv + 1, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
